// File: rtl/scan_reg_pkg.sv
// Shared sizing helpers for the scan register bank: counter width and legal WIDTH range.
package scan_reg_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  // Counter must be able to hold WIDTH itself (saturation value), not just WIDTH-1.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/scan_lockup_latch.sv
// Negative-level lockup latch on the scan output; holds SO stable across the
// high phase of CLK so the next chain segment samples the previous-cycle bit.
module scan_lockup_latch (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic so_q;

  always_latch begin
    if (rst)       so_q <= rst_val;
    else if (!clk) so_q <= d;
  end

  assign q = so_q;

endmodule

// File: rtl/scan_reg_bank.sv
// Scan-capable register bank: shift (SE) > load (EN) > hold, with a saturating shift counter.
// Optional macro SCAN_REG_BANK_LOCKUP_EN routes SO through a negative-level lockup latch.
module scan_reg_bank
  import scan_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       CLK,
  input  logic                       R,
  input  logic                       SE,
  input  logic                       SI,
  input  logic                       EN,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       SO,
  output logic [cnt_w(WIDTH)-1:0]    SHIFT_CNT,
  output logic                       CHAIN_FULL
);

  localparam int               CNT_W   = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("scan_reg_bank: WIDTH out of range");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (SE) begin
      q_d[0] = SI;
      for (int i = 1; i < WIDTH; i++) q_d[i] = q_q[i-1];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (EN) begin
      q_d   = D;
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      q_q   <= RESET_VALUE;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q          = q_q;
  assign SHIFT_CNT  = cnt_q;
  assign CHAIN_FULL = (cnt_q == CNT_MAX);

`ifdef SCAN_REG_BANK_LOCKUP_EN
  scan_lockup_latch u_lockup (
    .clk     (CLK),
    .rst     (R),
    .rst_val (RESET_VALUE[WIDTH-1]),
    .d       (q_q[WIDTH-1]),
    .q       (SO)
  );
`else
  assign SO = q_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed vector bench for scan_reg_bank (WIDTH=8, RESET_VALUE=8'hA5).
module tb_scan_reg_bank;

  localparam int W = 8;

  logic         CLK, R, SE, SI, EN;
  logic [W-1:0] D, Q;
  logic         SO, CHAIN_FULL;
  logic [3:0]   SHIFT_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  scan_reg_bank #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut (
    .CLK(CLK), .R(R), .SE(SE), .SI(SI), .EN(EN), .D(D),
    .Q(Q), .SO(SO), .SHIFT_CNT(SHIFT_CNT), .CHAIN_FULL(CHAIN_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         se, en, si;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic [3:0]   exp_cnt;
    logic         exp_full;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic se, en, si, input logic [W-1:0] d, exp_q,
                     input logic [3:0] exp_cnt, input logic exp_full);
    vec_t v;
    v.se = se; v.en = en; v.si = si; v.d = d;
    v.exp_q = exp_q; v.exp_cnt = exp_cnt; v.exp_full = exp_full;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string tag, input logic [W-1:0] eq,
                             input logic [3:0] ec, input logic ef);
    chk({tag, ".Q"}, 64'(Q), 64'(eq));
    chk({tag, ".CNT"}, 64'(SHIFT_CNT), 64'(ec));
    chk({tag, ".FULL"}, 64'(CHAIN_FULL), 64'(ef));
  endtask

  initial begin
    // se en si d      q      cnt full
    add(0, 1, 0, 8'h3C, 8'h3C, 0, 0);   // load
    add(0, 0, 0, 8'hFF, 8'h3C, 0, 0);   // hold
    add(0, 1, 0, 8'h00, 8'h00, 0, 0);   // load zero
    add(1, 0, 1, 8'h00, 8'h01, 1, 0);   // shift 1,0,1,1
    add(1, 0, 0, 8'h00, 8'h02, 2, 0);
    add(1, 0, 1, 8'h00, 8'h05, 3, 0);
    add(1, 0, 1, 8'h00, 8'h0B, 4, 0);
    add(0, 0, 1, 8'hFF, 8'h0B, 4, 0);   // hold keeps count
    add(1, 1, 0, 8'hFF, 8'h16, 5, 0);   // SE beats EN
    add(1, 0, 1, 8'h00, 8'h2D, 6, 0);
    add(1, 0, 1, 8'h00, 8'h5B, 7, 0);
    add(1, 0, 1, 8'h00, 8'hB7, 8, 1);
    add(1, 0, 0, 8'h00, 8'h6E, 8, 1);
    add(0, 1, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 1; i <= 10; i++)
      add(1, 0, 0, 8'h00, 8'h00, 4'((i > 8) ? 8 : i), (i >= 8));
    add(0, 1, 0, 8'h5A, 8'h5A, 0, 0);   // load clears saturated count

    R = 1'b1; SE = 0; SI = 0; EN = 0; D = '0;
    #2;
    check_state("reset", 8'hA5, 0, 0);
    chk("reset.SO", 64'(SO), 64'(1'b1));
    @(negedge CLK); R = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      SE = vecs[i].se; EN = vecs[i].en; SI = vecs[i].si; D = vecs[i].d;
      @(posedge CLK); #1;
      check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_full);
    end

    // Asynchronous reset mid-cycle, then an edge while still in reset
    @(negedge CLK); SE = 1; SI = 1; EN = 0;
    #3; R = 1'b1; #1;
    check_state("async_rst", 8'hA5, 0, 0);
    @(posedge CLK); #1;
    check_state("rst_edge", 8'hA5, 0, 0);
    @(negedge CLK); R = 1'b0; SE = 0; EN = 0;
    @(posedge CLK); #1;
    check_state("post_rst_hold", 8'hA5, 0, 0);
    @(negedge CLK); SE = 1; SI = 1;
    @(posedge CLK); #1;
    check_state("post_rst_shift", 8'h4B, 1, 0);

    // Scan-out timing: Q[7] goes 0 -> 1 on this edge
    @(negedge CLK); SE = 1; SI = 0;
    #2;
    chk("so_before", 64'(SO), 64'(1'b0));
    @(posedge CLK); #1;
    chk("so_q", 64'(Q), 64'(8'h96));
`ifdef SCAN_REG_BANK_LOCKUP_EN
    chk("so_rise", 64'(SO), 64'(1'b0));
`else
    chk("so_rise", 64'(SO), 64'(1'b1));
`endif
    @(negedge CLK); #1;
    chk("so_fall", 64'(SO), 64'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
